// File: rtl/mem_pkg.sv
// Shared types for the IF/LSU data-RAM arbiter.
// Access sizes, response owners and lane count.
package mem_pkg;

    localparam int LANES = 4;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LSU
    } mem_own_e;

    // Size 11 behaves as a word access.
    function automatic mem_size_e norm_size(input logic [1:0] s);
        case (s)
            2'b00:   return MEM_B;
            2'b01:   return MEM_H;
            default: return MEM_W;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and extraction/extension for loads.
// Purely combinational.
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            st_off,
    input  logic [1:0]            st_size,
    input  logic [DATA_WIDTH-1:0] st_wdata,
    output logic [LANES-1:0]      st_we,
    output logic [DATA_WIDTH-1:0] st_lanes,
    output logic                  st_misalign,
    input  logic [1:0]            ld_off,
    input  logic [1:0]            ld_size,
    input  logic                  ld_unsigned,
    input  logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [DATA_WIDTH-1:0] ld_data
);

    mem_size_e             st_sz;
    mem_size_e             ld_sz;
    logic [DATA_WIDTH-1:0] lane;
    logic                  sx;

    assign st_sz = norm_size(st_size);
    assign ld_sz = norm_size(ld_size);

    always_comb begin
        st_we       = '0;
        st_lanes    = st_wdata;
        st_misalign = 1'b0;
        unique case (1'b1)
            st_sz == MEM_B: begin
                st_lanes = {4{st_wdata[7:0]}};
                st_we    = 4'b0001 << st_off;
            end
            st_sz == MEM_H: begin
                st_lanes    = {2{st_wdata[15:0]}};
                st_we       = st_off[1] ? 4'b1100 : 4'b0011;
                st_misalign = st_off[0];
            end
            default: begin
                st_we       = 4'b1111;
                st_misalign = (st_off != 2'b00);
            end
        endcase
        if (st_misalign) begin
            st_we = '0;
        end
    end

    always_comb begin
        lane    = ld_rdata >> {ld_off, 3'b000};
        sx      = 1'b0;
        ld_data = ld_rdata;
        unique case (1'b1)
            ld_sz == MEM_B: begin
                sx      = ~ld_unsigned & lane[7];
                ld_data = {{24{sx}}, lane[7:0]};
            end
            ld_sz == MEM_H: begin
                sx      = ~ld_unsigned & lane[15];
                ld_data = {{16{sx}}, lane[15:0]};
            end
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-enabled data RAM between instruction fetch and the LSU.
// One grant per cycle; the response follows its grant by exactly one cycle.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_rsp_valid,
    output logic [DATA_WIDTH-1:0] if_rsp_data,
    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_we,
    input  logic [1:0]            lsu_size,
    input  logic                  lsu_unsigned,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    output logic                  lsu_rsp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rsp_data,
    output logic                  lsu_rsp_err,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_LSU_STREAK);

    logic [3:0]            streak_q, streak_d;
    mem_own_e              own_q, own_d;
    logic [1:0]            off_q, off_d;
    mem_size_e             size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  store_q, store_d;
    logic                  err_q, err_d;

    logic                  if_gnt, lsu_gnt, if_turn;
    logic [3:0]            st_we;
    logic [DATA_WIDTH-1:0] st_lanes, ld_data;
    logic                  st_misalign;
    logic                  unused_addr;

    assign unused_addr = ^if_addr[1:0];

    // IF only overtakes a waiting LSU once the streak budget is spent.
    assign if_turn = (streak_q == STREAK_MAX);
    assign if_gnt  = !rst && if_req_valid && (!lsu_req_valid || if_turn);
    assign lsu_gnt = !rst && lsu_req_valid && !(if_req_valid && if_turn);

    assign if_req_ready  = if_gnt;
    assign lsu_req_ready = lsu_gnt;

    mem_lane_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_align (
        .st_off     (lsu_addr[1:0]),
        .st_size    (lsu_size),
        .st_wdata   (lsu_wdata),
        .st_we      (st_we),
        .st_lanes   (st_lanes),
        .st_misalign(st_misalign),
        .ld_off     (off_q),
        .ld_size    (size_q),
        .ld_unsigned(uns_q),
        .ld_rdata   (ram_rdata),
        .ld_data    (ld_data)
    );

    always_comb begin
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (if_gnt) begin
            ram_addr = {if_addr[ADDR_WIDTH-1:2], 2'b00};
        end else if (lsu_gnt) begin
            ram_addr = lsu_addr;
            if (lsu_we) begin
                ram_we    = st_we;
                ram_wdata = st_lanes;
            end
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!if_req_valid || if_gnt) begin
            streak_d = '0;
        end else if (lsu_gnt && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
        end
        own_d   = if_gnt ? OWN_IF : (lsu_gnt ? OWN_LSU : OWN_NONE);
        off_d   = lsu_addr[1:0];
        size_d  = norm_size(lsu_size);
        uns_d   = lsu_unsigned;
        store_d = lsu_gnt && lsu_we;
        err_d   = lsu_gnt && st_misalign;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
            own_q    <= OWN_NONE;
            off_q    <= '0;
            size_q   <= MEM_B;
            uns_q    <= 1'b0;
            store_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            streak_q <= streak_d;
            own_q    <= own_d;
            off_q    <= off_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            store_q  <= store_d;
            err_q    <= err_d;
        end
    end

    assign if_rsp_valid  = (own_q == OWN_IF);
    assign if_rsp_data   = if_rsp_valid ? ram_rdata : '0;
    assign lsu_rsp_valid = (own_q == OWN_LSU);
    assign lsu_rsp_err   = lsu_rsp_valid && err_q;
    assign lsu_rsp_data  = (lsu_rsp_valid && !store_q && !err_q) ? ld_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte-enabled RAM model.
// Expected values are hand-computed from the intended RAM contents.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] lsu_wdata;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        lsu_rsp_err;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .MAX_LSU_STREAK(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .lsu_req_valid(lsu_req_valid),
        .lsu_req_ready(lsu_req_ready),
        .lsu_addr     (lsu_addr),
        .lsu_we       (lsu_we),
        .lsu_size     (lsu_size),
        .lsu_unsigned (lsu_unsigned),
        .lsu_wdata    (lsu_wdata),
        .lsu_rsp_valid(lsu_rsp_valid),
        .lsu_rsp_data (lsu_rsp_data),
        .lsu_rsp_err  (lsu_rsp_err),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first RAM: read data appears the cycle after the address.
    logic [31:0] ram [0:15];
    logic        ram_loaded = 1'b0;
    always @(posedge clk) begin
        logic [31:0] w;
        if (!ram_loaded) begin
            for (int i = 0; i < 16; i++) ram[i] <= (i == 1) ? 32'hDEAD_BEEF : 32'h0;
            ram_loaded <= 1'b1;
        end else begin
            w = ram[ram_addr[5:2]];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) w[8*b +: 8] = ram_wdata[8*b +: 8];
            ram[ram_addr[5:2]] <= w;
            ram_rdata <= w;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        if_req_valid  = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_we        = 1'b0;
    endtask

    task automatic drive_if(input logic [31:0] a);
        if_req_valid = 1'b1;
        if_addr      = a;
    endtask

    task automatic drive_lsu(input logic we, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd);
        lsu_req_valid = 1'b1;
        lsu_we        = we;
        lsu_size      = sz;
        lsu_unsigned  = uns;
        lsu_addr      = a;
        lsu_wdata     = wd;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        idle();
    endtask

    initial begin
        logic [9:0] pat;
        logic       prev_if;
        rst = 1'b1;
        idle();
        if_addr = '0; lsu_addr = '0; lsu_size = 2'b00;
        lsu_unsigned = 1'b0; lsu_wdata = '0;

        // Reset state, with both requesters asking
        next_cycle();
        drive_if(32'h4);
        drive_lsu(1'b1, 2'b10, 1'b0, 32'h0, 32'hFFFF_FFFF);
        #1;
        check("rst_if_ready", {31'b0, if_req_ready}, 0);
        check("rst_lsu_ready", {31'b0, lsu_req_ready}, 0);
        check("rst_ram_we", {28'b0, ram_we}, 0);
        check("rst_if_rsp_valid", {31'b0, if_rsp_valid}, 0);
        check("rst_lsu_rsp_valid", {31'b0, lsu_rsp_valid}, 0);
        check("rst_lsu_err", {31'b0, lsu_rsp_err}, 0);
        check("rst_if_rsp_data", if_rsp_data, 0);
        check("rst_lsu_rsp_data", lsu_rsp_data, 0);
        next_cycle();
        rst = 1'b0;

        // IF fetch at 0x6
        next_cycle(); drive_if(32'h6); #1;
        check("if_ready", {31'b0, if_req_ready}, 1);
        check("if_lsu_ready", {31'b0, lsu_req_ready}, 0);
        check("if_ram_addr", ram_addr, 32'h4);
        check("if_ram_we", {28'b0, ram_we}, 0);

        // SB 0xA5 at 0x2
        next_cycle(); drive_lsu(1'b1, 2'b00, 1'b0, 32'h2, 32'h1234_56A5); #1;
        check("if_rsp_valid", {31'b0, if_rsp_valid}, 1);
        check("if_rsp_data", if_rsp_data, 32'hDEAD_BEEF);
        check("sb_ready", {31'b0, lsu_req_ready}, 1);
        check("sb_ram_we", {28'b0, ram_we}, 32'h4);
        check("sb_ram_wdata", ram_wdata, 32'hA5A5_A5A5);
        check("sb_ram_addr", ram_addr, 32'h2);

        // LB at 0x2
        next_cycle(); drive_lsu(1'b0, 2'b00, 1'b0, 32'h2, 32'h0); #1;
        check("sb_ack_valid", {31'b0, lsu_rsp_valid}, 1);
        check("sb_ack_data", lsu_rsp_data, 0);
        check("sb_ack_if_valid", {31'b0, if_rsp_valid}, 0);
        check("lb_ram_we", {28'b0, ram_we}, 0);

        // LBU at 0x2
        next_cycle(); drive_lsu(1'b0, 2'b00, 1'b1, 32'h2, 32'h0); #1;
        check("lb_data", lsu_rsp_data, 32'hFFFF_FFA5);

        // SH 0x8001 at 0x6
        next_cycle(); drive_lsu(1'b1, 2'b01, 1'b0, 32'h6, 32'h0000_8001); #1;
        check("lbu_data", lsu_rsp_data, 32'h0000_00A5);
        check("sh_ram_we", {28'b0, ram_we}, 32'hC);
        check("sh_ram_wdata", ram_wdata, 32'h8001_8001);

        // LH at 0x6
        next_cycle(); drive_lsu(1'b0, 2'b01, 1'b0, 32'h6, 32'h0); #1;
        check("sh_ack_err", {31'b0, lsu_rsp_err}, 0);

        // Misaligned LW at 0x3
        next_cycle(); drive_lsu(1'b0, 2'b10, 1'b0, 32'h3, 32'h0); #1;
        check("lh_data", lsu_rsp_data, 32'hFFFF_8001);
        check("lw_mis_ready", {31'b0, lsu_req_ready}, 1);
        check("lw_mis_ram_we", {28'b0, ram_we}, 0);

        // SW at 0x8
        next_cycle(); drive_lsu(1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344); #1;
        check("lw_mis_valid", {31'b0, lsu_rsp_valid}, 1);
        check("lw_mis_err", {31'b0, lsu_rsp_err}, 1);
        check("lw_mis_data", lsu_rsp_data, 0);
        check("sw_ram_we", {28'b0, ram_we}, 32'hF);
        check("sw_ram_wdata", ram_wdata, 32'h1122_3344);

        // LHU at 0xA, then LB at 0x9
        next_cycle(); drive_lsu(1'b0, 2'b01, 1'b1, 32'hA, 32'h0); #1;
        check("sw_ack_err", {31'b0, lsu_rsp_err}, 0);
        next_cycle(); drive_lsu(1'b0, 2'b00, 1'b0, 32'h9, 32'h0); #1;
        check("lhu_data", lsu_rsp_data, 32'h0000_1122);

        // Misaligned SW at 0xE (size 11 behaves as word)
        next_cycle(); drive_lsu(1'b1, 2'b11, 1'b0, 32'hE, 32'hFFFF_FFFF); #1;
        check("lb9_data", lsu_rsp_data, 32'h0000_0033);
        check("sw_mis_ram_we", {28'b0, ram_we}, 0);
        next_cycle(); #1;
        check("sw_mis_err", {31'b0, lsu_rsp_err}, 1);
        check("idle_if_ready", {31'b0, if_req_ready}, 0);
        check("idle_lsu_ready", {31'b0, lsu_req_ready}, 0);

        // Both valid: LSU x4 then IF, repeating
        pat = 10'b10000_10000;
        prev_if = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            drive_if(32'h4);
            drive_lsu(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
            #1;
            check($sformatf("streak_if_ready%0d", i), {31'b0, if_req_ready}, {31'b0, pat[i]});
            check($sformatf("streak_lsu_ready%0d", i), {31'b0, lsu_req_ready}, {31'b0, ~pat[i]});
            if (i > 0) begin
                check($sformatf("streak_if_rsp%0d", i), {31'b0, if_rsp_valid}, {31'b0, prev_if});
                check($sformatf("streak_lsu_rsp%0d", i), {31'b0, lsu_rsp_valid}, {31'b0, ~prev_if});
                if (prev_if) check($sformatf("streak_if_data%0d", i), if_rsp_data, 32'h8001_BEEF);
                else check($sformatf("streak_lsu_data%0d", i), lsu_rsp_data, 32'h00A5_0000);
            end
            prev_if = pat[i];
        end
        next_cycle(); #1;
        check("streak_last_if_rsp", {31'b0, if_rsp_valid}, 1);
        check("streak_last_if_data", if_rsp_data, 32'h8001_BEEF);

        // Reset right after an LSU load grant drops the response
        next_cycle(); drive_lsu(1'b0, 2'b10, 1'b0, 32'h4, 32'h0); #1;
        check("rmid_grant", {31'b0, lsu_req_ready}, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive_if(32'h8);
        #1;
        check("rmid_lsu_rsp_valid", {31'b0, lsu_rsp_valid}, 0);
        check("rmid_lsu_rsp_data", lsu_rsp_data, 0);
        check("rmid_lsu_ready", {31'b0, lsu_req_ready}, 0);
        check("rmid_if_ready", {31'b0, if_req_ready}, 0);
        check("rmid_ram_we", {28'b0, ram_we}, 0);
        @(negedge clk); #1;
        check("rmid_lsu_rsp_valid2", {31'b0, lsu_rsp_valid}, 0);
        next_cycle();
        rst = 1'b0;
        drive_if(32'h8);
        #1;
        check("post_rst_if_ready", {31'b0, if_req_ready}, 1);
        check("post_rst_ram_addr", ram_addr, 32'h8);
        check("post_rst_lsu_valid", {31'b0, lsu_rsp_valid}, 0);
        next_cycle(); #1;
        check("post_rst_if_rsp", {31'b0, if_rsp_valid}, 1);
        check("post_rst_if_data", if_rsp_data, 32'h1122_3344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
